// File: rtl/key_event_arbiter.sv
// Key event arbiter: per-key press/release/auto-repeat detection feeding a
// single round-robin arbitrated event output register with valid/ready.
module key_event_arbiter #(
    parameter int w          = 4,
    parameter int rpt_delay  = 16,
    parameter int rpt_period = 8,
    parameter int cnt_w      = 8,
    localparam int KW        = (w > 1) ? $clog2(w) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [w-1:0]  key_db,
    input  logic          rpt_en,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [KW-1:0] ev_key,
    output logic [1:0]    ev_type,
    output logic          overflow
);

    localparam logic [cnt_w-1:0] DLY_LAST = cnt_w'(rpt_delay - 1);
    localparam logic [cnt_w-1:0] PER_LAST = cnt_w'(rpt_period - 1);

    logic [w-1:0]     r_prev;
    logic [w-1:0]     r_phase;
    logic [1:0]       r_pend [w];
    logic [cnt_w-1:0] r_cnt  [w];
    logic [KW-1:0]    r_last;

    logic [w-1:0]     w_press;
    logic [w-1:0]     w_rel;
    logic [w-1:0]     w_held;
    logic [w-1:0]     w_rpt;
    logic [1:0]       w_new [w];
    logic             w_load;
    logic             w_found;
    logic [KW-1:0]    w_gnt;
    logic [w-1:0]     w_gnt_oh;

    function automatic int rr_idx(input int base, input int k);
        int j;
        j = base + 1 + k;
        if (j >= w) j = j - w;
        return j;
    endfunction

    always_comb begin
        for (int i = 0; i < w; i++) begin
            w_press[i] = key_db[i] & ~r_prev[i];
            w_rel[i]   = ~key_db[i] & r_prev[i];
            w_held[i]  = key_db[i] & r_prev[i];
            w_rpt[i]   = rpt_en & w_held[i] &
                         (r_phase[i] ? (r_cnt[i] == PER_LAST)
                                     : (r_cnt[i] == DLY_LAST));
            w_new[i]   = w_press[i] ? 2'b01 :
                         w_rel[i]   ? 2'b10 :
                         w_rpt[i]   ? 2'b11 : 2'b00;
        end
    end

    // Round-robin search begins one past the last granted key.
    always_comb begin
        w_load   = ~ev_valid | ev_ready;
        w_found  = 1'b0;
        w_gnt    = '0;
        w_gnt_oh = '0;
        for (int k = 0; k < w; k++) begin
            if (!w_found && r_pend[rr_idx(int'(r_last), k)] != 2'b00) begin
                w_found = 1'b1;
                w_gnt   = KW'(rr_idx(int'(r_last), k));
                w_gnt_oh[rr_idx(int'(r_last), k)] = w_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= '0;
            r_phase  <= '0;
            r_last   <= KW'(w - 1);
            ev_valid <= 1'b0;
            ev_key   <= '0;
            ev_type  <= 2'b00;
            overflow <= 1'b0;
            for (int i = 0; i < w; i++) begin
                r_pend[i] <= 2'b00;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_prev <= key_db;
            for (int i = 0; i < w; i++) begin
                // A fresh event wins over the grant-clear on the same key.
                if (w_new[i] != 2'b00) begin
                    r_pend[i] <= w_new[i];
                    if (r_pend[i] != 2'b00 && !w_gnt_oh[i])
                        overflow <= 1'b1;
                end else if (w_gnt_oh[i]) begin
                    r_pend[i] <= 2'b00;
                end
                if (w_rpt[i]) begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= 1'b1;
                end else if (w_held[i] && rpt_en) begin
                    r_cnt[i]   <= r_cnt[i] + cnt_w'(1);
                end else begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= 1'b0;
                end
            end
            if (w_load) begin
                ev_valid <= w_found;
                if (w_found) begin
                    ev_key  <= w_gnt;
                    ev_type <= r_pend[w_gnt];
                    r_last  <= w_gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed literal scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_key_event_arbiter;

    localparam int W  = 4;
    localparam int D  = 16;
    localparam int P  = 8;
    localparam int KW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  key_db;
    logic          rpt_en;
    logic          ev_valid;
    logic          ev_ready;
    logic [KW-1:0] ev_key;
    logic [1:0]    ev_type;
    logic          overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    key_event_arbiter #(
        .w(W), .rpt_delay(D), .rpt_period(P), .cnt_w(8)
    ) dut (
        .clk(clk), .reset(reset), .key_db(key_db), .rpt_en(rpt_en),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key),
        .ev_type(ev_type), .overflow(overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: hold-run length decides repeats, pending slots
    // per key, one output slot, round-robin pointer.
    bit m_on = 0;
    int m_prev [W];
    int m_pend [W];
    int m_h    [W];
    int m_valid, m_key, m_type, m_ovf, m_last;

    task automatic model_step();
        int nt [W];
        int g, gtype, load, j, kd, held;
        if (reset) begin
            for (int i = 0; i < W; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_h[i] = 0;
            end
            m_valid = 0; m_key = 0; m_type = 0; m_ovf = 0;
            m_last = W - 1; m_on = 1;
            return;
        end
        if (!m_on) return;
        g = -1; gtype = 0;
        load = (m_valid == 0 || ev_ready) ? 1 : 0;
        if (load != 0) begin
            for (int k = 0; k < W; k++) begin
                j = (m_last + 1 + k) % W;
                if (g < 0 && m_pend[j] != 0) g = j;
            end
            if (g >= 0) gtype = m_pend[g];
        end
        for (int i = 0; i < W; i++) begin
            kd = int'(key_db[i]);
            held = (kd != 0 && m_prev[i] != 0) ? 1 : 0;
            if (held != 0 && rpt_en) m_h[i]++;
            else m_h[i] = 0;
            nt[i] = 0;
            if (kd != 0 && m_prev[i] == 0) nt[i] = 1;
            else if (kd == 0 && m_prev[i] != 0) nt[i] = 2;
            else if (m_h[i] >= D && (m_h[i] - D) % P == 0) nt[i] = 3;
        end
        for (int i = 0; i < W; i++) begin
            if (nt[i] != 0) begin
                if (m_pend[i] != 0 && i != g) m_ovf = 1;
                m_pend[i] = nt[i];
            end else if (i == g) begin
                m_pend[i] = 0;
            end
            m_prev[i] = int'(key_db[i]);
        end
        if (load != 0) begin
            if (g >= 0) begin
                m_valid = 1; m_key = g; m_type = gtype; m_last = g;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_on) begin
            check("m_valid", int'(ev_valid), m_valid);
            if (m_valid != 0) begin
                check("m_key", int'(ev_key), m_key);
                check("m_type", int'(ev_type), m_type);
            end
            check("m_ovf", int'(overflow), m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_ev(input string nm, input int k, input int t);
        check({nm, "_valid"}, int'(ev_valid), 1);
        check({nm, "_key"}, int'(ev_key), k);
        check({nm, "_type"}, int'(ev_type), t);
    endtask

    initial begin
        int exp_t;
        reset = 1'b1; key_db = '0; rpt_en = 1'b1; ev_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", int'(ev_valid), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_key", int'(ev_key), 0);
        check("rst_type", int'(ev_type), 0);
        reset = 1'b0;
        tick();

        // single press latency
        key_db = 4'b0100;
        tick();
        check("lat_early", int'(ev_valid), 0);
        tick();
        expect_ev("lat", 2, 1);
        tick();
        check("lat_once", int'(ev_valid), 0);

        // simultaneous presses, one per cycle
        key_db = '0;
        do_reset();
        key_db = 4'b1111;
        tick();
        check("all_early", int'(ev_valid), 0);
        for (int k = 0; k < W; k++) begin
            tick();
            expect_ev("all", k, 1);
        end
        tick();
        check("all_done", int'(ev_valid), 0);

        // auto-repeat timing
        key_db = '0;
        do_reset();
        key_db = 4'b0010;
        for (int n = 1; n <= 44; n++) begin
            tick();
            if (n == 2 || n == 18 || n == 26 || n == 34 ||
                n == 42 || n == 43) begin
                exp_t = (n == 2) ? 1 : (n == 43) ? 2 : 3;
                expect_ev("rpt", 1, exp_t);
            end else begin
                check("rpt_idle", int'(ev_valid), 0);
            end
            if (n == 41) key_db = '0;
        end

        // overwrite while output is blocked, then stall stability
        do_reset();
        ev_ready = 1'b0;
        rpt_en = 1'b0;
        key_db = 4'b0010;
        tick();
        tick();
        key_db = 4'b0011;
        tick();
        key_db = 4'b0010;
        tick();
        check("ovw_ovf", int'(overflow), 1);
        expect_ev("ovw_hold", 1, 1);
        for (int n = 0; n < 5; n++) begin
            tick();
            expect_ev("stall", 1, 1);
        end
        ev_ready = 1'b1;
        tick();
        expect_ev("ovw_rel", 0, 2);
        tick();
        check("ovw_empty", int'(ev_valid), 0);
        check("ovw_sticky", int'(overflow), 1);

        // reset with events pending, held keys re-report
        ev_ready = 1'b0;
        key_db = 4'b1111;
        tick();
        reset = 1'b1;
        tick();
        check("rp_valid", int'(ev_valid), 0);
        check("rp_ovf", int'(overflow), 0);
        reset = 1'b0;
        tick();
        check("rp_gap", int'(ev_valid), 0);
        tick();
        expect_ev("rp_k0", 0, 1);
        ev_ready = 1'b1;
        for (int k = 1; k < W; k++) begin
            tick();
            expect_ev("rp_k", k, 1);
        end

        // randomized traffic, checked by the model process
        rpt_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 23) == 0) key_db[i] = ~key_db[i];
            rpt_en = ($urandom_range(0, 29) != 0);
            ev_ready = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter w, default 4: number of keys.
REQ-002 SHALL have parameter rpt_delay, default 16: cycles from press detection to first repeat event; legal range >= 2.
REQ-003 SHALL have parameter rpt_period, default 8: cycles between subsequent repeat events; legal range >= 2.
REQ-004 SHALL have parameter cnt_w, default 8: repeat counter width; 2^cnt_w > max(rpt_delay, rpt_period).
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port key_db, input, w: debounced, synchronized key levels, 1 = pressed.
REQ-008 SHALL have port rpt_en, input, 1: auto-repeat enable.
REQ-009 SHALL have port ev_valid, output, 1: event available.
REQ-010 SHALL have port ev_ready, input, 1: consumer accepts event.
REQ-011 SHALL have port ev_key, output, $clog2(w) (min 1): index of key owning the event.
REQ-012 SHALL have port ev_type, output, 2: 01 press, 10 release, 11 repeat.
REQ-013 SHALL have port overflow, output, 1: sticky flag, an unconsumed event was overwritten.

Function
REQ-014 SHALL keep per key a prev level register; press edge = key_db & ~prev, release edge = ~key_db & prev, both detected in the cycle key_db changes.
REQ-015 SHALL keep per key a 2-bit pending register (00 = none) written with the detected event type on the clock edge ending the detection cycle.
REQ-016 SHALL, if a new event targets a key whose pending is non-zero and not being granted that cycle, overwrite pending with the new type and set overflow.
REQ-017 SHALL keep per key a cnt_w-bit counter and a phase bit: on press edge, counter = 0, phase = 0; while held, counter increments each cycle.
REQ-018 SHALL, when rpt_en = 1, key held, phase = 0 and counter == rpt_delay-1, post a repeat event, clear the counter and set phase = 1.
REQ-019 SHALL, when rpt_en = 1, key held, phase = 1 and counter == rpt_period-1, post a repeat event and clear the counter.
REQ-020 SHALL, on release edge or when rpt_en = 0, clear counter and phase; repeat timing restarts from the next press.
REQ-021 SHALL hold one output register (ev_valid, ev_key, ev_type), loadable when ev_valid = 0 or (ev_valid & ev_ready).
REQ-022 SHALL, when loadable and any pending is non-zero, grant round-robin: search starts at index last_grant+1 mod w; grant loads the output register and clears that key's pending on the same edge.
REQ-023 SHALL give priority to a new event over the clear when both target the same key in one cycle: pending takes the new type, no overflow.
REQ-024 SHALL keep ev_key/ev_type stable while ev_valid = 1 and ev_ready = 0.
REQ-025 SHALL sustain one event per cycle under continuous ev_ready = 1.
REQ-026 SHALL have latency 2 cycles from the key_db change to ev_valid when output and pending are empty.
REQ-027 SHALL never emit an event for a key with pending = 00 and never drop an accepted event.

Reset
REQ-028 SHALL, while reset = 1 at a rising edge, clear prev, pending, counters, phase, last_grant (to w-1, so index 0 searches first), ev_valid, ev_key, ev_type and overflow.
REQ-029 SHALL report a key held through reset as a press event after reset deasserts, because prev resets to 0.
REQ-030 SHALL let reset mid-transaction discard all pending and in-flight events with no output glitch after the reset edge.

Verification
REQ-031 SHALL pass: key_db[2] 0->1, ev_ready = 1 -> ev_valid two cycles later, ev_key = 2, ev_type = 01, for one cycle.
REQ-032 SHALL pass: key_db = 4'b1111 same cycle, ev_ready = 1 -> keys 0,1,2,3 press events on four consecutive cycles.
REQ-033 SHALL pass: key_db[1] held 40 cycles, rpt_en = 1, defaults -> press, then repeats at +16, +24, +32, +40 cycles after detection, release on let-go.
REQ-034 SHALL pass: ev_ready = 0, key_db[0] press then release -> pending overwritten to 10, overflow = 1, ev_valid stuck with the first event until ready.
REQ-035 SHALL pass: ev_ready low 5 cycles with ev_valid = 1 -> ev_key/ev_type unchanged throughout.
REQ-036 SHALL pass: reset pulse while three events pending -> ev_valid = 0, overflow = 0 next cycle; held keys re-report as press.
